// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter:
//   - default address/data widths of the dmem port
//   - owner tags recording which requester a read belongs to
//   - lock FSM state encoding
//   - helper mapping a requester index (0 = processor, 1 = auxiliary)
//     to its owner tag
package dmem_arbiter_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_PROC = 2'd1;
    localparam logic [1:0] OWN_AUX  = 2'd2;

    typedef enum logic {
        LOCK_OPEN   = 1'b0,
        LOCK_LOCKED = 1'b1
    } lock_state_t;

    function automatic logic [1:0] owner_of(input int idx);
        return (idx == 0) ? OWN_PROC : OWN_AUX;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2
// Two-way grant unit, reusable wherever one single-port resource is shared
// by two masters (dmem, imem).
//   clock  : clock
//   reset  : asynchronous active-low reset
//   req[1:0] : request vector (bit 0 = requester 0, bit 1 = requester 1)
//   gnt[1:0] : one-hot (or zero) grant, combinational from req and pointer
// FIXED_PRIO = 0 : round-robin, a tie goes to the requester not granted last
// FIXED_PRIO = 1 : requester 0 always wins a tie
module rr_arb2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // 0: requester 0 wins the next tie, 1: requester 1 wins it.
    logic prio_reg;

    generate
        if (FIXED_PRIO) begin : g_fixed
            always_comb begin
                gnt = 2'b00;
                if (req[0]) begin
                    gnt = 2'b01;
                end else if (req[1]) begin
                    gnt = 2'b10;
                end
            end
        end else begin : g_rr
            always_comb begin
                gnt = 2'b00;
                case (req)
                    2'b01:   gnt = 2'b01;
                    2'b10:   gnt = 2'b10;
                    2'b11:   gnt = prio_reg ? 2'b10 : 2'b01;
                    default: gnt = 2'b00;
                endcase
            end
        end
    endgenerate

    // Pointer moves only when something is granted, so idle cycles keep
    // the fairness history.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prio_reg <= 1'b0;
        end else if (gnt[0]) begin
            prio_reg <= 1'b1;
        end else if (gnt[1]) begin
            prio_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port synchronous dmem (1-cycle read latency) between the
// processor (p_*) and an auxiliary master (a_*: loader / debug / display).
// At most one access is issued per cycle; read data is routed back to the
// requester that issued the read.
// Ports:
//   clock, reset        : memory clock, asynchronous active-low reset
//   p_req/p_wren/p_addr/p_wdata : processor request
//   p_gnt/p_rvalid/p_rdata      : processor grant pulse and read return
//   a_req/a_wren/a_addr/a_wdata : auxiliary request
//   a_lock                      : auxiliary keeps ownership across grants
//   a_gnt/a_rvalid/a_rdata      : auxiliary grant pulse and read return
//   address_dmem/data/wren      : dmem port
//   q_dmem                      : dmem read data
// Optional macro DMEM_ARB_PERF_EN adds p_grant_cnt, a_grant_cnt and
// a_stall_cnt (32-bit wrapping event counters).
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p_req,
    input  logic              p_wren,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              a_req,
    input  logic              a_wren,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              a_lock,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic [ADDR_W-1:0] address_dmem,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q_dmem
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       p_grant_cnt,
    output logic [31:0]       a_grant_cnt,
    output logic [31:0]       a_stall_cnt
`endif
);

    lock_state_t       lock_state_reg, lock_state_next;
    logic              run_reg;
    logic [1:0]        req_vec;
    logic [1:0]        gnt_vec;
    logic [ADDR_W-1:0] addr_hold_reg;
    logic [DATA_W-1:0] data_hold_reg;
    logic [1:0]        owner_reg, owner_next;
    logic [1:0]        rvalid_out;
    logic [DATA_W-1:0] rdata_out [2];

    // run_reg is cleared by the asynchronous reset and set on the first edge
    // after release; gating requests with it keeps every grant (and thus
    // wren) low for as long as reset is asserted, without feeding the raw
    // reset net into combinational logic.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
        end
    end

    // While locked the processor request is masked, which also overrides
    // fixed priority.
    assign req_vec[0] = run_reg & p_req & (lock_state_reg == LOCK_OPEN);
    assign req_vec[1] = run_reg & a_req;

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clock (clock),
        .reset (reset),
        .req   (req_vec),
        .gnt   (gnt_vec)
    );

    assign p_gnt = gnt_vec[0];
    assign a_gnt = gnt_vec[1];

    // Lock FSM: the auxiliary enters a burst by being granted with a_lock
    // high and leaves it as soon as it lowers a_lock or a_req.
    always_comb begin
        lock_state_next = lock_state_reg;
        case (lock_state_reg)
            LOCK_OPEN: begin
                if (a_gnt && a_lock) begin
                    lock_state_next = LOCK_LOCKED;
                end
            end
            LOCK_LOCKED: begin
                if (!a_lock || !a_req) begin
                    lock_state_next = LOCK_OPEN;
                end
            end
            default: lock_state_next = LOCK_OPEN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lock_state_reg <= LOCK_OPEN;
        end else begin
            lock_state_reg <= lock_state_next;
        end
    end

    // dmem port mux. Address/data hold their last value when idle so the
    // memory inputs do not toggle needlessly; wren is only ever high with a
    // grant. owner_next tags a read so its data can be steered next cycle.
    always_comb begin
        address_dmem = addr_hold_reg;
        data         = data_hold_reg;
        wren         = 1'b0;
        owner_next   = OWN_NONE;
        if (gnt_vec[0]) begin
            address_dmem = p_addr;
            data         = p_wdata;
            wren         = p_wren;
            owner_next   = p_wren ? OWN_NONE : OWN_PROC;
        end else if (gnt_vec[1]) begin
            address_dmem = a_addr;
            data         = a_wdata;
            wren         = a_wren;
            owner_next   = a_wren ? OWN_NONE : OWN_AUX;
        end
    end

    // The owner tag is re-registered every cycle, so a read in N followed
    // by any access in N+1 returns to the correct requester.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_hold_reg <= '0;
            data_hold_reg <= '0;
            owner_reg     <= OWN_NONE;
        end else begin
            addr_hold_reg <= address_dmem;
            data_hold_reg <= data;
            owner_reg     <= owner_next;
        end
    end

    // Read return per requester: q_dmem passes straight through in the
    // return cycle and is captured so rdata holds until the next return.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ret
            localparam logic [1:0] OWN_CODE = owner_of(gi);
            logic [DATA_W-1:0] rdata_reg;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    rdata_reg <= '0;
                end else if (owner_reg == OWN_CODE) begin
                    rdata_reg <= q_dmem;
                end
            end

            assign rvalid_out[gi] = (owner_reg == OWN_CODE);
            assign rdata_out[gi]  = rvalid_out[gi] ? q_dmem : rdata_reg;
        end
    endgenerate

    assign p_rvalid = rvalid_out[0];
    assign p_rdata  = rdata_out[0];
    assign a_rvalid = rvalid_out[1];
    assign a_rdata  = rdata_out[1];

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p_grant_cnt <= '0;
            a_grant_cnt <= '0;
            a_stall_cnt <= '0;
        end else begin
            if (p_gnt) begin
                p_grant_cnt <= p_grant_cnt + 32'd1;
            end
            if (a_gnt) begin
                a_grant_cnt <= a_grant_cnt + 32'd1;
            end
            if (a_req && !a_gnt) begin
                a_stall_cnt <= a_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Drives one round-robin instance (index 0) and one fixed-priority instance
// (index 1) with identical per-cycle request vectors. Each instance has its
// own behavioural dmem. Expected grants come from the vector table; read
// data expectations are queued at grant time and compared on return.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;

    logic clock    = 1'b0;
    logic reset    = 1'b0;
    logic mem_init = 1'b1;

    always #5 clock = ~clock;

    logic          p_req, p_wren, a_req, a_wren, a_lock;
    logic [AW-1:0] p_addr, a_addr;
    logic [DW-1:0] p_wdata, a_wdata;

    logic [1:0]    p_gnt_w, a_gnt_w, p_rvalid_w, a_rvalid_w, wren_w;
    logic [AW-1:0] addr_w    [2];
    logic [DW-1:0] data_w    [2];
    logic [DW-1:0] q_w       [2];
    logic [DW-1:0] p_rdata_w [2];
    logic [DW-1:0] a_rdata_w [2];
`ifdef DMEM_ARB_PERF_EN
    logic [31:0]   pgc_w [2];
    logic [31:0]   agc_w [2];
    logic [31:0]   asc_w [2];
`endif

    logic [DW-1:0] mem [2][4096];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            dmem_arbiter #(
                .ADDR_W     (AW),
                .DATA_W     (DW),
                .FIXED_PRIO (gi == 1)
            ) u_dut (
                .clock        (clock),
                .reset        (reset),
                .p_req        (p_req),
                .p_wren       (p_wren),
                .p_addr       (p_addr),
                .p_wdata      (p_wdata),
                .p_gnt        (p_gnt_w[gi]),
                .p_rvalid     (p_rvalid_w[gi]),
                .p_rdata      (p_rdata_w[gi]),
                .a_req        (a_req),
                .a_wren       (a_wren),
                .a_addr       (a_addr),
                .a_wdata      (a_wdata),
                .a_lock       (a_lock),
                .a_gnt        (a_gnt_w[gi]),
                .a_rvalid     (a_rvalid_w[gi]),
                .a_rdata      (a_rdata_w[gi]),
                .address_dmem (addr_w[gi]),
                .data         (data_w[gi]),
                .wren         (wren_w[gi]),
                .q_dmem       (q_w[gi])
`ifdef DMEM_ARB_PERF_EN
                ,
                .p_grant_cnt  (pgc_w[gi]),
                .a_grant_cnt  (agc_w[gi]),
                .a_stall_cnt  (asc_w[gi])
`endif
            );
        end
    endgenerate

    function automatic logic [31:0] pat(input logic [11:0] a);
        return (a == 12'h010) ? 32'hDEADBEEF : {20'hC0DE0, a};
    endfunction

    // Behavioural single-port synchronous memories, preloaded during reset.
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_init) begin
                for (int i = 0; i < 4096; i++) mem[k][i] <= pat(i[11:0]);
            end else if (wren_w[k]) begin
                mem[k][addr_w[k]] <= data_w[k];
            end
            q_w[k] <= mem[k][addr_w[k]];
        end
    end

    typedef struct {
        string       name;
        logic        p_req;
        logic        p_wren;
        logic [11:0] p_addr;
        logic [31:0] p_wdata;
        logic        a_req;
        logic        a_wren;
        logic        a_lock;
        logic [11:0] a_addr;
        logic [31:0] a_wdata;
        logic [1:0]  exp_rr;   // {a_gnt, p_gnt} expected, round-robin
        logic [1:0]  exp_fp;   // {a_gnt, p_gnt} expected, fixed priority
    } vec_t;

    typedef struct {
        int          inst;
        int          who;      // 0 = processor, 1 = auxiliary
        logic [31:0] data;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_addr  [2];
    logic [31:0] exp_data  [2];
    logic [31:0] exp_rdata [2][2];
    logic [31:0] shadow0 [logic [11:0]];
    logic [31:0] shadow1 [logic [11:0]];

    localparam logic [1:0] GN = 2'b00;
    localparam logic [1:0] GP = 2'b01;
    localparam logic [1:0] GA = 2'b10;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %h expected %h", name, k, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_exp(input int k, input logic [11:0] a);
        if (k == 0) return shadow0.exists(a) ? shadow0[a] : pat(a);
        return shadow1.exists(a) ? shadow1[a] : pat(a);
    endfunction

    task automatic shadow_wr(input int k, input logic [11:0] a, input logic [31:0] d);
        if (k == 0) shadow0[a] = d;
        else        shadow1[a] = d;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            exp_addr[k] = '0;
            exp_data[k] = '0;
            exp_rdata[k][0] = '0;
            exp_rdata[k][1] = '0;
        end
        sb.delete();
    endtask

    task automatic addv(input string name,
                        input logic pr, input logic pw, input logic [11:0] pa, input logic [31:0] pd,
                        input logic ar, input logic aw, input logic al, input logic [11:0] aa,
                        input logic [31:0] ad, input logic [1:0] err, input logic [1:0] efp);
        vec_t v;
        v.name = name; v.p_req = pr; v.p_wren = pw; v.p_addr = pa; v.p_wdata = pd;
        v.a_req = ar; v.a_wren = aw; v.a_lock = al; v.a_addr = aa; v.a_wdata = ad;
        v.exp_rr = err; v.exp_fp = efp;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        p_req = v.p_req; p_wren = v.p_wren; p_addr = v.p_addr; p_wdata = v.p_wdata;
        a_req = v.a_req; a_wren = v.a_wren; a_lock = v.a_lock; a_addr = v.a_addr; a_wdata = v.a_wdata;
    endtask

    // Registered outputs: read returns due from the previous cycle's grants.
    task automatic check_rsp();
        logic [1:0] ev [2];
        sb_t e;
        ev[0] = 2'b00;
        ev[1] = 2'b00;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ev[e.inst][e.who] = 1'b1;
            exp_rdata[e.inst][e.who] = e.data;
        end
        for (int k = 0; k < 2; k++) begin
            chk("p_rvalid", k, {31'd0, p_rvalid_w[k]}, {31'd0, ev[k][0]});
            chk("a_rvalid", k, {31'd0, a_rvalid_w[k]}, {31'd0, ev[k][1]});
            chk("p_rdata", k, p_rdata_w[k], exp_rdata[k][0]);
            chk("a_rdata", k, a_rdata_w[k], exp_rdata[k][1]);
        end
    endtask

    // Combinational outputs in the cycle the vector is applied.
    task automatic check_gnt(input vec_t v);
        logic [1:0]  eg;
        logic [11:0] ga;
        logic [31:0] gd;
        logic        gw;
        int          who;
        for (int k = 0; k < 2; k++) begin
            eg = (k == 0) ? v.exp_rr : v.exp_fp;
            ga = '0; gd = '0; gw = 1'b0; who = 0;
            chk({v.name, " gnt"}, k, {30'd0, a_gnt_w[k], p_gnt_w[k]}, {30'd0, eg});
            if (eg == GP) begin
                ga = v.p_addr; gd = v.p_wdata; gw = v.p_wren; who = 0;
            end else if (eg == GA) begin
                ga = v.a_addr; gd = v.a_wdata; gw = v.a_wren; who = 1;
            end
            if (eg != GN) begin
                exp_addr[k] = {20'd0, ga};
                exp_data[k] = gd;
                if (gw) shadow_wr(k, ga, gd);
                else    sb.push_back('{k, who, rd_exp(k, ga)});
            end
            chk({v.name, " addr"}, k, {20'd0, addr_w[k]}, exp_addr[k]);
            chk({v.name, " data"}, k, data_w[k], exp_data[k]);
            chk({v.name, " wren"}, k, {31'd0, wren_w[k]}, {31'd0, (eg != GN) && gw});
        end
    endtask

    task automatic step(input vec_t v);
        @(negedge clock);
        check_rsp();
        drive(v);
        #1;
        check_gnt(v);
        $display("[%0t] %-12s rr a/p=%b%b fp a/p=%b%b", $time, v.name,
                 a_gnt_w[0], p_gnt_w[0], a_gnt_w[1], p_gnt_w[1]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle;
        idle = '{"idle", 0, 0, 12'h0, 32'h0, 0, 0, 0, 12'h0, 32'h0, GN, GN};

        // name          pr pw paddr   pwdata         ar aw al aaddr   awdata  rr  fp
        addv("p_rd010",    1, 0, 12'h010, 32'hA0000010, 0, 0, 0, 12'h000, 32'h0, GP, GP);
        addv("a_rd011",    0, 0, 12'h000, 32'h0,        1, 0, 0, 12'h011, 32'hB0000011, GA, GA);
        for (int i = 0; i < 8; i++) begin
            addv($sformatf("both%0d", i), 1, 0, 12'h030, 32'hA0000030,
                 1, 0, 0, 12'h040, 32'hB0000040, (i % 2 == 0) ? GP : GA, GP);
        end
        addv("a_only",     0, 0, 12'h000, 32'h0,        1, 0, 0, 12'h041, 32'hB0000041, GA, GA);
        addv("idle",       0, 0, 12'h000, 32'h0,        0, 0, 0, 12'h000, 32'h0, GN, GN);
        addv("p_wr020",    1, 1, 12'h020, 32'h55,       0, 0, 0, 12'h000, 32'h0, GP, GP);
        addv("a_rd020",    0, 0, 12'h000, 32'h0,        1, 0, 0, 12'h020, 32'hB0000020, GA, GA);
        addv("burst0",     0, 0, 12'h000, 32'h0,        1, 1, 1, 12'h100, 32'h1, GA, GA);
        addv("burst1",     1, 0, 12'h050, 32'hA0000050, 1, 1, 1, 12'h101, 32'h2, GA, GA);
        addv("burst2",     1, 0, 12'h050, 32'hA0000050, 1, 1, 1, 12'h102, 32'h3, GA, GA);
        addv("burst3",     1, 0, 12'h050, 32'hA0000050, 1, 1, 0, 12'h103, 32'h4, GA, GA);
        addv("p_after",    1, 0, 12'h050, 32'hA0000050, 0, 0, 0, 12'h000, 32'h0, GP, GP);
        for (int i = 0; i < 4; i++) begin
            addv($sformatf("rb%0d", i), 0, 0, 12'h000, 32'h0,
                 1, 0, 0, 12'h100 + 12'(i), 32'hB0000100, GA, GA);
        end
        addv("lock_hold",  0, 0, 12'h000, 32'h0,        1, 0, 1, 12'h012, 32'hB0000012, GA, GA);
        addv("lock_drop",  1, 0, 12'h013, 32'hA0000013, 0, 0, 0, 12'h000, 32'h0, GN, GN);
        addv("p_unlock",   1, 0, 12'h013, 32'hA0000013, 0, 0, 0, 12'h000, 32'h0, GP, GP);
        addv("rr_a_first", 1, 0, 12'h014, 32'hA0000014, 1, 0, 0, 12'h015, 32'hB0000015, GA, GP);
        addv("p_last",     1, 0, 12'h016, 32'hA0000016, 0, 0, 0, 12'h000, 32'h0, GP, GP);

        // Reset with both requesting: nothing may be granted.
        model_reset();
        reset = 1'b0;
        mem_init = 1'b1;
        drive('{"rst", 1, 1, 12'h3FF, 32'hFFFFFFFF, 1, 1, 1, 12'h3FE, 32'hFFFFFFFF, GN, GN});
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            chk("rst p_gnt", k, {31'd0, p_gnt_w[k]}, 32'd0);
            chk("rst a_gnt", k, {31'd0, a_gnt_w[k]}, 32'd0);
            chk("rst wren", k, {31'd0, wren_w[k]}, 32'd0);
            chk("rst addr", k, {20'd0, addr_w[k]}, 32'd0);
            chk("rst data", k, data_w[k], 32'd0);
            chk("rst p_rvalid", k, {31'd0, p_rvalid_w[k]}, 32'd0);
            chk("rst a_rvalid", k, {31'd0, a_rvalid_w[k]}, 32'd0);
            chk("rst p_rdata", k, p_rdata_w[k], 32'd0);
        end
        drive(idle);
        reset = 1'b1;
        mem_init = 1'b0;

        foreach (vecs[i]) step(vecs[i]);

        // Reset asserted while a processor read is being granted.
        @(negedge clock);
        check_rsp();
        drive('{"rst_mid", 1, 0, 12'h010, 32'h0, 0, 0, 0, 12'h000, 32'h0, GP, GP});
        #1;
        for (int k = 0; k < 2; k++) chk("rst_mid p_gnt pre", k, {31'd0, p_gnt_w[k]}, 32'd1);
        reset = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            chk("rst_mid p_gnt", k, {31'd0, p_gnt_w[k]}, 32'd0);
            chk("rst_mid wren", k, {31'd0, wren_w[k]}, 32'd0);
            chk("rst_mid addr", k, {20'd0, addr_w[k]}, 32'd0);
            chk("rst_mid p_rdata", k, p_rdata_w[k], 32'd0);
            chk("rst_mid a_rdata", k, a_rdata_w[k], 32'd0);
        end
        $display("[%0t] rst_mid      reset asserted during read grant", $time);
        @(negedge clock);
        for (int k = 0; k < 2; k++) chk("rst_mid p_rvalid", k, {31'd0, p_rvalid_w[k]}, 32'd0);
        drive(idle);
        reset = 1'b1;

        // Pointer back at the processor after reset.
        step('{"post_rst", 1, 0, 12'h017, 32'hA0000017, 1, 0, 0, 12'h018, 32'hB0000018, GP, GP});
        step(idle);
        step(idle);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
